arm_imm_encoder: RTL and testbench
==================================

Name: arm_imm_encoder

Overview:
- Iterative encoder for the ARMv4 data-processing rotated immediate: finds imm8 and rot such that value = ROR(zero_ext(imm8), 2*rot).
- Counterpart of the datapath's immediate rotate-right decode path.
- Used by the instruction-generation/self-test logic to build immediates and to flag values that are not encodable.
- Tests one rotation candidate per clock under a start/done handshake.

Parameters:
- N, 32, data width; only 32 is supported, since rotation arithmetic is modulo 32.
- ROT_W, 4, width of the rotation field; 16 candidates, each rotating by an even amount.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- value  input  N  32-bit constant to encode; captured when start is accepted.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle completion pulse.
- valid  output  1  result is encodable; meaningful from done onward.
- rot  output  ROT_W  rotation field; rotate amount = 2*rot.
- imm8  output  8  8-bit immediate field.

Behaviour:
- Reset (async, active-high): state=IDLE, cnt=0, value_q=0; busy=0, done=0, valid=0, rot=0, imm8=0. Applies at any time, including mid-search, and aborts the search with no done pulse.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - On a clk edge with start=1: value_q<=value, cnt<=0, go to SEARCH, busy<=1.
  - valid/rot/imm8 keep the previous result.
- SEARCH, each cycle:
  - cand = ROL(value_q, 2*cnt), a 32-bit circular left shift.
  - Hit when cand[31:8]==0.
  - On hit, at the next edge: rot<=cnt, imm8<=cand[7:0], valid<=1, go to DONE.
  - On miss with cnt<15: cnt<=cnt+1.
  - On miss with cnt==15: rot<=0, imm8<=0, valid<=0, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Canonical result: the smallest rot that hits wins. Example: 0x00000004 gives rot=0, not rot=1 with imm8=0x10.
- Latency:
  - For a hit at candidate r, done is high in the cycle following the (r+2)th rising edge after the edge that accepted start. Range 2..17 edges.
  - For a miss, done follows the 17th edge.
- busy is high from the accepting edge until the edge that enters DONE.
- start is ignored while busy=1 or during the DONE cycle; value changes after acceptance have no effect.
- rot/imm8/valid are stable from done until the next accepted start, and also stable throughout the following search.
- value=0: hit at r=0, imm8=0x00, valid=1.
- Shift arithmetic: rotation amount is 2*cnt, a 5-bit quantity in 0..30; there is no 32-rotation case.
- Outputs are registered; there is no combinational path from start/value to the outputs.

Test Plan:
- Reset, then start with value=0x000000FF -> done after 2 edges, valid=1, rot=0, imm8=0xFF; busy high for exactly 1 cycle before done.
- value=0xFF000000 -> valid=1, rot=4, imm8=0xFF, done at edge 6; check ROR(0xFF,8)==value.
- value=0xF000000F (wrap-around) -> valid=1, rot=2, imm8=0xFF. value=0x00000004 -> rot=0, imm8=0x04 (canonical smallest rot).
- value=0x00000101 (not encodable) -> done at edge 17, valid=0, rot=0, imm8=0. Then a new start with 0x3FC -> valid=1, rot=15, imm8=0xFF; check ROR(0xFF,30)=0x3FC.
- Start 0x00000101, pulse start again with 0xFF at cycle 3, and change value mid-search -> second start ignored; result stays the not-encodable result for 0x101; exactly one done pulse.
- Assert reset asynchronously (between edges) at cycle 5 of a search -> busy/done/valid/rot/imm8 go to 0 immediately, no done pulse. After release, start with 0x00AB0000 -> valid=1, rot=8, imm8=0xAB.

Source files
------------

// File: rtl/arm_imm_encoder_if.sv
// Start/done request bus for the rotated-immediate encoder.
// The master issues a value to encode; the slave returns imm8/rot and a valid flag.
interface arm_imm_encoder_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned ROT_W = 4
);
  logic             start;
  logic [N-1:0]     value;
  logic             busy;
  logic             done;
  logic             valid;
  logic [ROT_W-1:0] rot;
  logic [7:0]       imm8;

  modport master (output start, value, input busy, done, valid, rot, imm8);
  modport slave  (input start, value, output busy, done, valid, rot, imm8);
endinterface

// File: rtl/arm_imm_encoder.sv
// Iterative ARMv4 rotated-immediate encoder: tests one even rotation per clock
// and returns the smallest rot with value == ROR(imm8, 2*rot).
module arm_imm_encoder #(
  parameter int unsigned N     = 32,
  parameter int unsigned ROT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  arm_imm_encoder_if.slave    bus
);

  localparam int unsigned SH_W = ROT_W + 1;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t           state, state_n;
  logic [ROT_W-1:0] cnt, cnt_n;
  logic [N-1:0]     value_q, value_q_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             valid_q, valid_n;
  logic [ROT_W-1:0] rot_q, rot_n;
  logic [7:0]       imm8_q, imm8_n;

  logic [SH_W-1:0]  sh_c;
  logic [2*N-1:0]   dbl_c;
  logic [N-1:0]     cand_c;
  logic             hit_c;

  // Candidate for the current count: left-rotate by 2*cnt via a doubled word.
  always_comb begin
    sh_c   = {cnt, 1'b0};
    dbl_c  = {value_q, value_q} << sh_c;
    cand_c = dbl_c[2*N-1:N];
    hit_c  = (cand_c[N-1:8] == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      value_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      rot_q   <= '0;
      imm8_q  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      value_q <= value_q_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      valid_q <= valid_n;
      rot_q   <= rot_n;
      imm8_q  <= imm8_n;
    end
  end

  // Next state; result fields hold unless a search completes.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    value_q_n = value_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    valid_n   = valid_q;
    rot_n     = rot_q;
    imm8_n    = imm8_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          value_q_n = bus.value;
          cnt_n     = '0;
          busy_n    = 1'b1;
          state_n   = SEARCH;
        end
      end
      SEARCH: begin
        if (hit_c) begin
          rot_n   = cnt;
          imm8_n  = cand_c[7:0];
          valid_n = 1'b1;
          busy_n  = 1'b0;
          state_n = DONE;
        end else if (&cnt) begin
          rot_n   = '0;
          imm8_n  = '0;
          valid_n = 1'b0;
          busy_n  = 1'b0;
          state_n = DONE;
        end else begin
          cnt_n = cnt + ROT_W'(1);
        end
      end
      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.valid = valid_q;
  assign bus.rot   = rot_q;
  assign bus.imm8  = imm8_q;

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Scoreboard bench for arm_imm_encoder: directed values with hand-computed
// imm8/rot/latency, checked by an independent done monitor.
module tb_arm_imm_encoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arm_imm_encoder_if #(.N(32), .ROT_W(4)) bus ();
  arm_imm_encoder #(.N(32), .ROT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] value;
    logic        valid;
    logic [3:0]  rot;
    logic [7:0]  imm8;
    int          done_cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [7:0] imm, input logic [3:0] r);
    logic [63:0] d;
    logic [4:0]  s;
    s = {r, 1'b0};
    d = {24'd0, imm, 24'd0, imm} >> s;
    return d[31:0];
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("valid",   32'(bus.valid), 32'(mon_e.valid));
        check("rot",     32'(bus.rot),   32'(mon_e.rot));
        check("imm8",    32'(bus.imm8),  32'(mon_e.imm8));
        check("latency", 32'(cyc),       32'(mon_e.done_cyc));
        if (mon_e.valid) check("ror_back", ror32(bus.imm8, bus.rot), mon_e.value);
      end
    end
  end

  task automatic issue(input logic [31:0] v, input logic vld, input logic [3:0] r,
                       input logic [7:0] imm, input int lat);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = v;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    e.value    = v;
    e.valid    = vld;
    e.rot      = r;
    e.imm8     = imm;
    e.done_cyc = cyc + lat;
    sbq.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sbq.size() == 0) break;
    end
    if (sbq.size() != 0) begin
      check({name, "_timeout"}, 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.value = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_rot",   32'(bus.rot),   32'd0);
    check("rst_imm8",  32'(bus.imm8),  32'd0);
    reset = 1'b0;

    // Immediate hit at rot 0; busy for one cycle, then the DONE cycle.
    issue(32'h0000_00FF, 1'b1, 4'd0, 8'hFF, 2);
    @(negedge clk);
    check("t1_busy_search", 32'(bus.busy), 32'd1);
    check("t1_done_early",  32'(bus.done), 32'd0);
    @(negedge clk);
    check("t1_busy_donest", 32'(bus.busy), 32'd0);
    check("t1_done_donest", 32'(bus.done), 32'd0);
    wait_idle("t1");

    issue(32'hFF00_0000, 1'b1, 4'd4, 8'hFF, 6);
    wait_idle("t2");

    // Previous result holds during the next search.
    issue(32'hF000_000F, 1'b1, 4'd2, 8'hFF, 4);
    @(negedge clk);
    check("hold_valid", 32'(bus.valid), 32'd1);
    check("hold_rot",   32'(bus.rot),   32'd4);
    check("hold_imm8",  32'(bus.imm8),  32'hFF);
    wait_idle("t3");

    issue(32'h0000_0004, 1'b1, 4'd0, 8'h04, 2);
    wait_idle("t4");
    issue(32'h0000_0000, 1'b1, 4'd0, 8'h00, 2);
    wait_idle("t4z");

    issue(32'h0000_0101, 1'b0, 4'd0, 8'h00, 17);
    wait_idle("t5");
    issue(32'h0000_03FC, 1'b1, 4'd15, 8'hFF, 17);
    wait_idle("t6");

    // Restart attempt and value change mid-search are ignored.
    issue(32'h0000_0101, 1'b0, 4'd0, 8'h00, 17);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = 32'h0000_00FF;
    @(negedge clk);
    bus.start = 1'b0;
    bus.value = 32'h1234_5678;
    check("t7_busy_mid", 32'(bus.busy), 32'd1);
    wait_idle("t7");
    repeat (3) @(negedge clk);

    // Async reset mid-search clears outputs at once and suppresses done.
    issue(32'hFF00_0000, 1'b1, 4'd4, 8'hFF, 6);
    wait_idle("t8a");
    issue(32'h0000_0101, 1'b0, 4'd0, 8'h00, 17);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    sbq.delete();
    check("arst_busy",  32'(bus.busy),  32'd0);
    check("arst_done",  32'(bus.done),  32'd0);
    check("arst_valid", 32'(bus.valid), 32'd0);
    check("arst_rot",   32'(bus.rot),   32'd0);
    check("arst_imm8",  32'(bus.imm8),  32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("arst_no_done_busy", 32'(bus.busy), 32'd0);

    issue(32'h00AB_0000, 1'b1, 4'd8, 8'hAB, 10);
    wait_idle("t9");
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
